// File: rtl/ddr_phy_pkg.sv
// Shared types for the DDR PHY lane delay sequencer: command opcodes, FSM
// states and the lane-index width helper.
package ddr_phy_pkg;

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_LOAD,
    ST_FINISH
  } state_e;

  // A single-lane build still needs a 1-bit lane index port.
  function automatic int lane_w(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

endpackage

// File: rtl/ddr_tap_counter.sv
// Saturating tap tracker for one delay lane; mirrors the tap position the
// delay line should be at after each MOVE or LOAD strobe.
module ddr_tap_counter #(
  parameter int TAP_W    = 8,
  parameter int INIT_TAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  output logic [TAP_W-1:0] tap,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [TAP_W-1:0] INIT_VAL = TAP_W'(INIT_TAP);

  assign at_max = &tap;
  assign at_min = ~|tap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap <= INIT_VAL;
    end else if (load) begin
      tap <= INIT_VAL;
    end else if (inc && !at_max) begin
      tap <= tap + TAP_W'(1);
    end else if (dec && !at_min) begin
      tap <= tap - TAP_W'(1);
    end
  end

endmodule

// File: rtl/ddr_lane_dly_seq.sv
// Sequences inc/dec/load commands onto per-lane PHY delay-line controls,
// spacing MOVE strobes by MOVE_GAP idle cycles and tracking each lane's tap.
module ddr_lane_dly_seq
  import ddr_phy_pkg::*;
#(
  parameter int  NUM_LANES = 2,
  parameter int  TAP_W     = 8,
  parameter int  MOVE_GAP  = 4,
  parameter int  INIT_TAP  = 1,
  localparam int LW        = lane_w(NUM_LANES)
) (
  input  logic                       FAB_CLK,
  input  logic                       ARST_N,
  input  logic                       CMD_VALID,
  output logic                       CMD_READY,
  input  logic [LW-1:0]              CMD_LANE,
  input  logic [1:0]                 CMD_OP,
  input  logic [TAP_W-1:0]           CMD_STEPS,
  output logic [NUM_LANES-1:0]       DLY_SEL,
  output logic [NUM_LANES-1:0]       DLY_DIRECTION,
  output logic [NUM_LANES-1:0]       DLY_MOVE,
  output logic [NUM_LANES-1:0]       DLY_LOAD,
  input  logic [NUM_LANES-1:0]       OOR,
  output logic [NUM_LANES*TAP_W-1:0] TAP_CNT,
  output logic                       DONE,
  output logic                       ERR
);

  localparam int             GAP_W    = 4;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MOVE_GAP - 1);

  state_e               state_q, state_d;
  op_e                  op_q;
  logic [LW-1:0]        lane_q;
  logic [TAP_W-1:0]     steps_q;
  logic [GAP_W-1:0]     gap_q;
  logic                 err_q, err_d;
  logic [NUM_LANES-1:0] lane_hot, at_max, at_min;
  logic [NUM_LANES-1:0] tap_inc, tap_dec, tap_load;
  logic                 accept, cmd_bad, limit, oor_lane, active, steering;

  assign accept   = CMD_VALID && CMD_READY;
  assign cmd_bad  = (op_e'(CMD_OP) == OP_RSVD) || (int'(CMD_LANE) >= NUM_LANES);
  assign limit    = (op_q == OP_INC) ? |(lane_hot & at_max) : |(lane_hot & at_min);
  assign oor_lane = |(lane_hot & OOR);
  assign active   = state_q inside {ST_SETUP, ST_PULSE, ST_GAP, ST_LOAD};
  assign steering = state_q inside {ST_SETUP, ST_PULSE, ST_GAP};

  // An out-of-range lane index decodes to no lane at all.
  always_comb begin
    lane_hot = '0;
    for (int i = 0; i < NUM_LANES; i++) lane_hot[i] = (int'(lane_q) == i);
  end

  assign tap_inc  = (state_q == ST_PULSE && op_q == OP_INC && !limit) ? lane_hot : '0;
  assign tap_dec  = (state_q == ST_PULSE && op_q == OP_DEC && !limit) ? lane_hot : '0;
  assign tap_load = (state_q == ST_LOAD) ? lane_hot : '0;

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise a path that skips an assignment infers a latch.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d = cmd_bad;
          if (cmd_bad)                         state_d = ST_FINISH;
          else if (op_e'(CMD_OP) == OP_LOAD)   state_d = ST_SETUP;
          else if (CMD_STEPS == '0)            state_d = ST_FINISH;
          else                                 state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = (op_q == OP_LOAD) ? ST_LOAD : ST_PULSE;
      ST_PULSE: begin
        if (limit) begin
          state_d = ST_FINISH;
          err_d   = 1'b1;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (oor_lane) begin
          state_d = ST_FINISH;
          err_d   = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          state_d = (steps_q == '0) ? ST_FINISH : ST_PULSE;
        end
      end
      ST_LOAD:   state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= ST_IDLE;
      op_q    <= OP_INC;
      lane_q  <= '0;
      steps_q <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      gap_q   <= (state_q == ST_GAP) ? gap_q + GAP_W'(1) : '0;
      if (accept) begin
        op_q    <= op_e'(CMD_OP);
        lane_q  <= CMD_LANE;
        steps_q <= CMD_STEPS;
      end else if (state_q == ST_PULSE && !limit) begin
        steps_q <= steps_q - TAP_W'(1);
      end
    end
  end

  // Registered outputs trail the state by one cycle; READY looks at the next
  // state so it drops in the very cycle after an accept.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      CMD_READY     <= 1'b0;
      DLY_SEL       <= '0;
      DLY_DIRECTION <= '0;
      DLY_MOVE      <= '0;
      DLY_LOAD      <= '0;
      DONE          <= 1'b0;
      ERR           <= 1'b0;
    end else begin
      CMD_READY     <= (state_d == ST_IDLE);
      DLY_SEL       <= active ? lane_hot : '0;
      DLY_DIRECTION <= (steering && op_q == OP_INC) ? lane_hot : '0;
      DLY_MOVE      <= tap_inc | tap_dec;
      DLY_LOAD      <= tap_load;
      DONE          <= (state_q == ST_FINISH);
      ERR           <= (state_q == ST_FINISH) && err_q;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ddr_tap_counter #(
      .TAP_W   (TAP_W),
      .INIT_TAP(INIT_TAP)
    ) u_tap (
      .clk   (FAB_CLK),
      .rst_n (ARST_N),
      .inc   (tap_inc[i]),
      .dec   (tap_dec[i]),
      .load  (tap_load[i]),
      .tap   (TAP_CNT[i*TAP_W +: TAP_W]),
      .at_max(at_max[i]),
      .at_min(at_min[i])
    );
  end

endmodule

// File: tb/tb_ddr_lane_dly_seq.sv
// Directed bench for ddr_lane_dly_seq: commands push predicted outcomes to a
// scoreboard that a negedge monitor retires on each DONE pulse.
module tb_ddr_lane_dly_seq;

  localparam int NL   = 2;
  localparam int TW   = 8;
  localparam int G    = 4;
  localparam int INIT = 1;
  localparam logic [NL*TW-1:0] ALL_INIT  = {NL{TW'(INIT)}};
  localparam logic [3*TW-1:0]  ALL_INIT3 = {3{TW'(INIT)}};

  typedef struct {
    int               lane;
    int               moves;
    int               loads;
    int               lat;
    int               oor_after;
    logic             err;
    logic             dir;
    logic [NL*TW-1:0] taps;
  } exp_t;

  logic fab_clk = 1'b0;
  logic arst_n  = 1'b1;
  always #5 fab_clk = ~fab_clk;

  logic             cmd_valid = 1'b0, cmd_ready;
  logic [0:0]       cmd_lane  = '0;
  logic [1:0]       cmd_op    = '0;
  logic [TW-1:0]    cmd_steps = '0;
  logic [NL-1:0]    dly_sel, dly_direction, dly_move, dly_load;
  logic [NL-1:0]    oor = '0;
  logic [NL*TW-1:0] tap_cnt;
  logic             done, err;

  logic             c3_valid = 1'b0, c3_ready;
  logic [1:0]       c3_lane  = '0;
  logic [1:0]       c3_op    = '0;
  logic [TW-1:0]    c3_steps = '0;
  logic [2:0]       c3_sel, c3_direction, c3_move, c3_load;
  logic [2:0]       c3_oor = '0;
  logic [3*TW-1:0]  c3_taps;
  logic             c3_done, c3_err;

  ddr_lane_dly_seq #(.NUM_LANES(NL), .TAP_W(TW), .MOVE_GAP(G), .INIT_TAP(INIT)) u_dut (
    .FAB_CLK(fab_clk), .ARST_N(arst_n),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_LANE(cmd_lane),
    .CMD_OP(cmd_op), .CMD_STEPS(cmd_steps),
    .DLY_SEL(dly_sel), .DLY_DIRECTION(dly_direction), .DLY_MOVE(dly_move),
    .DLY_LOAD(dly_load), .OOR(oor), .TAP_CNT(tap_cnt), .DONE(done), .ERR(err)
  );

  ddr_lane_dly_seq #(.NUM_LANES(3), .TAP_W(TW), .MOVE_GAP(G), .INIT_TAP(INIT)) u_dut3 (
    .FAB_CLK(fab_clk), .ARST_N(arst_n),
    .CMD_VALID(c3_valid), .CMD_READY(c3_ready), .CMD_LANE(c3_lane),
    .CMD_OP(c3_op), .CMD_STEPS(c3_steps),
    .DLY_SEL(c3_sel), .DLY_DIRECTION(c3_direction), .DLY_MOVE(c3_move),
    .DLY_LOAD(c3_load), .OOR(c3_oor), .TAP_CNT(c3_taps), .DONE(c3_done), .ERR(c3_err)
  );

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, accept_cyc = 0;
  int mv_cnt = 0, ld_cnt = 0, last_mv = 0;
  logic stray = 1'b0;
  logic [TW-1:0] mtap [NL];
  exp_t exp_q [$];
  exp_t cur;

  always @(posedge fab_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Predict the outcome, queue it, then offer the command until accepted.
  task automatic issue(input int op, input int lane, input int steps, input int oor_after);
    exp_t e;
    int   w;
    e.lane = lane; e.moves = 0; e.loads = 0; e.lat = 1; e.err = 1'b0;
    e.dir = (op == 0); e.oor_after = oor_after;
    if (op == 3 || lane >= NL) begin
      e.err = 1'b1;
    end else if (op == 2) begin
      mtap[lane] = TW'(INIT);
      e.loads    = 1;
      e.lat      = 3;
    end else if (steps > 0) begin
      e.lat = 2 + steps * (1 + G);
      for (int i = 0; i < steps; i++) begin
        if ((op == 0 && mtap[lane] == '1) || (op == 1 && mtap[lane] == '0)) begin
          e.err = 1'b1;
          e.lat = 3 + i * (1 + G);
          break;
        end
        mtap[lane] = (op == 0) ? mtap[lane] + TW'(1) : mtap[lane] - TW'(1);
        e.moves++;
        if (e.moves == oor_after) begin
          e.err = 1'b1;
          e.lat = 4 + i * (1 + G);
          break;
        end
      end
    end
    for (int i = 0; i < NL; i++) e.taps[i*TW +: TW] = mtap[i];
    exp_q.push_back(e);
    w = 0;
    @(negedge fab_clk);
    while (!cmd_ready && w < 50) begin
      @(negedge fab_clk);
      w++;
    end
    if (!cmd_ready) check("ready_wait", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_lane  = 1'(lane);
    cmd_op    = 2'(op);
    cmd_steps = TW'(steps);
    @(posedge fab_clk);
    #1;
    accept_cyc = cyc;
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(negedge fab_clk);
      w++;
    end
    check({tag, "_retired"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic reset_pulse();
    #1 arst_n = 1'b0;
    #1;
    check("rst_outputs", 64'({cmd_ready, dly_sel, dly_direction, dly_move, dly_load, done, err}), 64'(0));
    check("rst_taps", 64'(tap_cnt), 64'(ALL_INIT));
    for (int i = 0; i < NL; i++) mtap[i] = TW'(INIT);
    repeat (3) @(negedge fab_clk);
    #2 arst_n = 1'b1;
    #1 check("ready_low_before_edge", 64'(cmd_ready), 64'(0));
    @(posedge fab_clk);
    #1 check("ready_after_release", 64'(cmd_ready), 64'(1));
  endtask

  // Scoreboard monitor: tallies strobes of the current command, retires it on DONE.
  always @(negedge fab_clk) begin
    if (!arst_n) begin
      exp_q.delete();
      mv_cnt = 0; ld_cnt = 0; stray = 1'b0; oor = '0;
    end else if (exp_q.size() == 0) begin
      check("no_unexpected_done", 64'(done), 64'(0));
    end else begin
      logic [NL-1:0] other;
      cur   = exp_q[0];
      other = '1;
      other[cur.lane] = 1'b0;
      if (|(other & (dly_sel | dly_direction | dly_move | dly_load)) || (err && !done))
        stray = 1'b1;
      if (dly_move[cur.lane]) begin
        mv_cnt++;
        check("move_dir", 64'(dly_direction[cur.lane]), 64'(cur.dir));
        if (mv_cnt > 1) check("move_spacing", 64'(cyc - last_mv), 64'(G + 1));
        last_mv = cyc;
        if (mv_cnt == cur.oor_after) oor[cur.lane] = 1'b1;
      end
      if (dly_load[cur.lane]) ld_cnt++;
      if (done) begin
        void'(exp_q.pop_front());
        check("done_err",     64'(err), 64'(cur.err));
        check("done_taps",    64'(tap_cnt), 64'(cur.taps));
        check("done_moves",   64'(mv_cnt), 64'(cur.moves));
        check("done_loads",   64'(ld_cnt), 64'(cur.loads));
        check("done_latency", 64'(cyc - accept_cyc), 64'(cur.lat));
        check("done_stray",   64'(stray), 64'(0));
        check("done_dly_idle", 64'({dly_sel, dly_direction, dly_move, dly_load}), 64'(0));
        mv_cnt = 0; ld_cnt = 0; stray = 1'b0; oor = '0;
      end
    end
  end

  initial begin
    logic [11:0] acc;
    int          w, c3_acc;
    for (int i = 0; i < NL; i++) mtap[i] = TW'(INIT);

    #2 reset_pulse();

    issue(0, 1, 3, 0);   wait_done("inc_lane1_x3");
    issue(0, 0, 10, 2);  wait_done("inc_oor_abort");
    issue(1, 0, 3, 0);   wait_done("dec_to_zero");
    issue(1, 0, 2, 0);   wait_done("dec_at_zero");
    issue(0, 1, 3, 0);   wait_done("inc_to_7");
    issue(2, 1, 0, 0);   wait_done("load_lane1");
    issue(0, 0, 0, 0);   wait_done("zero_steps");
    issue(3, 1, 4, 0);   wait_done("reserved_op");
    issue(0, 1, 255, 0); wait_done("inc_saturate");

    // Lane index beyond NUM_LANES on a 3-lane instance.
    w = 0;
    @(negedge fab_clk);
    while (!c3_ready && w < 20) begin
      @(negedge fab_clk);
      w++;
    end
    c3_valid = 1'b1; c3_lane = 2'd3; c3_op = 2'b00; c3_steps = TW'(2);
    @(posedge fab_clk);
    #1 c3_acc = cyc;
    c3_valid = 1'b0;
    acc = '0; w = 0;
    while (!c3_done && w < 20) begin
      @(negedge fab_clk);
      acc |= {c3_sel, c3_direction, c3_move, c3_load};
      w++;
    end
    check("bad_lane_latency", 64'(cyc - c3_acc), 64'(1));
    check("bad_lane_err",     64'(c3_err), 64'(1));
    check("bad_lane_strobes", 64'(acc), 64'(0));
    check("bad_lane_taps",    64'(c3_taps), 64'(ALL_INIT3));

    // Reset in the first GAP of a 5-step command discards it.
    issue(0, 0, 5, 0);
    w = 0;
    while (mv_cnt < 1 && w < 50) begin
      @(negedge fab_clk);
      w++;
    end
    check("sel_in_gap", 64'(dly_sel), 64'(1));
    reset_pulse();
    repeat (12) @(negedge fab_clk);

    issue(0, 0, 1, 0);   wait_done("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
